multi_ch_fifo: RTL and testbench

Single-clock, multi-channel FIFO holding NUM_CH independent first-word-fall-through (FWFT) queues, each backed by its own RAM. It has per-channel programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and occupancy counters. It sits between channelised stream producers and consumers on one clock domain. It replaces hand-instantiated banks of single sync FIFOs.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_ch.sv | 118 +++++++++++
 rtl/multi_ch_fifo.sv | 72 +++++++
 tb/tb_multi_ch_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the multi-channel FIFO
//
// Purpose: width helper for occupancy counters, channel-slice helper for
// packed per-channel vectors, and the per-channel flag bundle type.
// Ports: none (package).

package fifo_pkg;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Low bit of channel ch inside a packed vector of w-bit lanes.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

  // Status bundle produced by every channel.
  typedef struct packed {
    logic empty;
    logic full;
    logic a_empty;
    logic a_full;
    logic overflow;
    logic underflow;
  } ch_flags_t;

endpackage

// File: rtl/fifo_ch.sv
// rtl/fifo_ch.sv - one first-word-fall-through FIFO channel
//
// Purpose: RAM-backed FWFT queue with an output register, occupancy count,
// registered threshold flags and sticky overflow/underflow flags.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, wr_data         write request and data
//   pop                   consume the head word
//   err_clr               clear sticky error flags
//   a_empty_thresh        a_empty when count <= threshold
//   a_full_thresh         a_full when count >= threshold
//   rd_data               head word, valid while flags.empty is low
//   data_cnt              words held, including the output register
//   flags                 empty/full/a_empty/a_full/overflow/underflow

module fifo_ch
  import fifo_pkg::*;
#(
  parameter int    FIFO_WIDTH = 32,
  parameter int    FIFO_DEPTH = 128,
  parameter string RAM_STYLE  = "block",
  localparam int   CNT_W      = cnt_w(FIFO_DEPTH),
  localparam int   PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  pop,
  input  logic                  err_clr,
  input  logic [CNT_W-1:0]      a_empty_thresh,
  input  logic [CNT_W-1:0]      a_full_thresh,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      data_cnt,
  output ch_flags_t             flags
);

  (* ram_style = RAM_STYLE *)
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             out_valid;
  logic             full_q, a_empty_q, a_full_q, ovf_q, unf_q;
  logic             push_ok, pop_ok, prefetch, ram_has_data;
  logic [CNT_W-1:0] cnt_next;

  assign push_ok      = push && !full_q;
  assign pop_ok       = pop && out_valid;
  // Words still in RAM = total count minus the one held in the output register.
  assign ram_has_data = (data_cnt != {{(CNT_W-1){1'b0}}, out_valid});
  // Refill the output register whenever it is free or being consumed.
  assign prefetch     = ram_has_data && (!out_valid || pop_ok);

  always_comb begin
    cnt_next = data_cnt;
    case ({push_ok, pop_ok})
      2'b10:   cnt_next = data_cnt + CNT_W'(1);
      2'b01:   cnt_next = data_cnt - CNT_W'(1);
      default: cnt_next = data_cnt;
    endcase
  end

  // RAM array: no reset so it can map onto memory primitives.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      rd_data   <= '0;
      data_cnt  <= '0;
      full_q    <= 1'b0;
      a_empty_q <= 1'b1;
      a_full_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (prefetch) begin
        rd_data   <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_valid <= 1'b1;
      end else if (pop_ok) begin
        out_valid <= 1'b0;
      end
      data_cnt  <= cnt_next;
      full_q    <= (cnt_next == CNT_W'(FIFO_DEPTH));
      a_empty_q <= (cnt_next <= a_empty_thresh);
      a_full_q  <= (cnt_next >= a_full_thresh);
      // A new error in the same cycle wins over the clear.
      if (push && full_q) begin
        ovf_q <= 1'b1;
      end else if (err_clr) begin
        ovf_q <= 1'b0;
      end
      if (pop && !out_valid) begin
        unf_q <= 1'b1;
      end else if (err_clr) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign flags = '{empty:     !out_valid,
                   full:      full_q,
                   a_empty:   a_empty_q,
                   a_full:    a_full_q,
                   overflow:  ovf_q,
                   underflow: unf_q};

endmodule

// File: rtl/multi_ch_fifo.sv
// rtl/multi_ch_fifo.sv - bank of independent FWFT FIFO channels
//
// Purpose: NUM_CH independent fifo_ch instances; channel c uses slice
// [c*W +: W] of every packed per-channel vector.
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   push_i, wr_data_i                    per-channel write request and data
//   pop_i                                per-channel head consume
//   rd_data_o                            per-channel head word
//   empty_o, full_o                      head not valid / no space
//   a_empty_thresh_i, a_full_thresh_i    per-channel thresholds
//   a_empty_o, a_full_o                  threshold flags
//   data_cnt_o                           per-channel occupancy
//   overflow_o, underflow_o, err_clr_i   sticky error flags and their clear

module multi_ch_fifo
  import fifo_pkg::*;
#(
  parameter int    NUM_CH     = 4,
  parameter int    FIFO_WIDTH = 32,
  parameter int    FIFO_DEPTH = 128,
  parameter string RAM_STYLE  = "block",
  localparam int   CNT_W      = cnt_w(FIFO_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            push_i,
  input  logic [NUM_CH*FIFO_WIDTH-1:0] wr_data_i,
  input  logic [NUM_CH-1:0]            pop_i,
  output logic [NUM_CH*FIFO_WIDTH-1:0] rd_data_o,
  output logic [NUM_CH-1:0]            empty_o,
  output logic [NUM_CH-1:0]            full_o,
  input  logic [NUM_CH*CNT_W-1:0]      a_empty_thresh_i,
  input  logic [NUM_CH*CNT_W-1:0]      a_full_thresh_i,
  output logic [NUM_CH-1:0]            a_empty_o,
  output logic [NUM_CH-1:0]            a_full_o,
  output logic [NUM_CH*CNT_W-1:0]      data_cnt_o,
  output logic [NUM_CH-1:0]            overflow_o,
  output logic [NUM_CH-1:0]            underflow_o,
  input  logic [NUM_CH-1:0]            err_clr_i
);

  ch_flags_t ch_flags [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_ch #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .RAM_STYLE  (RAM_STYLE)
    ) u_ch (
      .clk            (clk_i),
      .rst            (rst_i),
      .push           (push_i[c]),
      .wr_data        (wr_data_i[slice_lo(c, FIFO_WIDTH) +: FIFO_WIDTH]),
      .pop            (pop_i[c]),
      .err_clr        (err_clr_i[c]),
      .a_empty_thresh (a_empty_thresh_i[slice_lo(c, CNT_W) +: CNT_W]),
      .a_full_thresh  (a_full_thresh_i[slice_lo(c, CNT_W) +: CNT_W]),
      .rd_data        (rd_data_o[slice_lo(c, FIFO_WIDTH) +: FIFO_WIDTH]),
      .data_cnt       (data_cnt_o[slice_lo(c, CNT_W) +: CNT_W]),
      .flags          (ch_flags[c])
    );

    assign empty_o[c]     = ch_flags[c].empty;
    assign full_o[c]      = ch_flags[c].full;
    assign a_empty_o[c]   = ch_flags[c].a_empty;
    assign a_full_o[c]    = ch_flags[c].a_full;
    assign overflow_o[c]  = ch_flags[c].overflow;
    assign underflow_o[c] = ch_flags[c].underflow;
  end

endmodule

// File: tb/tb_multi_ch_fifo.sv
// tb/tb_multi_ch_fifo.sv - self-checking bench for multi_ch_fifo

module tb_multi_ch_fifo;

  localparam int NCH   = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    push = '0, pop = '0, clr = '0;
  logic [NCH*W-1:0]  wdata = '0;
  logic [NCH*CW-1:0] ae_th, af_th;
  logic [NCH*W-1:0]  rd_data;
  logic [NCH-1:0]    empty, full, a_empty, a_full, ovf, unf;
  logic [NCH*CW-1:0] cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: contents as queues, plus head-visible and registered flags.
  logic [W-1:0] mq [NCH][$];
  bit hv [NCH];
  bit m_full [NCH], m_ae [NCH], m_af [NCH], m_ovf [NCH], m_unf [NCH];

  always #5 clk = ~clk;

  multi_ch_fifo #(
    .NUM_CH     (NCH),
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (DEPTH),
    .RAM_STYLE  ("block")
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .push_i           (push),
    .wr_data_i        (wdata),
    .pop_i            (pop),
    .rd_data_o        (rd_data),
    .empty_o          (empty),
    .full_o           (full),
    .a_empty_thresh_i (ae_th),
    .a_full_thresh_i  (af_th),
    .a_empty_o        (a_empty),
    .a_full_o         (a_full),
    .data_cnt_o       (cnt),
    .overflow_o       (ovf),
    .underflow_o      (unf),
    .err_clr_i        (clr)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned th(input logic [NCH*CW-1:0] v, input int c);
    return int'(v[c*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      hv[c] = 0; m_full[c] = 0; m_ae[c] = 1; m_af[c] = 0;
      m_ovf[c] = 0; m_unf[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int sz;
      int nsz;
      bit p_ok, q_ok, new_hv;
      sz   = mq[c].size();
      p_ok = push[c] && (sz < DEPTH);
      q_ok = pop[c] && hv[c];
      if (q_ok) begin
        void'(mq[c].pop_front());
        new_hv = (mq[c].size() > 0);
      end else begin
        // An older stored word becomes visible one cycle after it arrived.
        new_hv = hv[c] || (sz > 0);
      end
      if (p_ok) mq[c].push_back(wdata[c*W +: W]);
      if (push[c] && sz == DEPTH) m_ovf[c] = 1;
      else if (clr[c])            m_ovf[c] = 0;
      if (pop[c] && !hv[c])       m_unf[c] = 1;
      else if (clr[c])            m_unf[c] = 0;
      hv[c]     = new_hv;
      nsz       = mq[c].size();
      m_full[c] = (nsz == DEPTH);
      m_ae[c]   = (nsz <= th(ae_th, c));
      m_af[c]   = (nsz >= th(af_th, c));
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("empty ch%0d", c),     W'(empty[c]),   W'(!hv[c]));
      chk($sformatf("full ch%0d", c),      W'(full[c]),    W'(m_full[c]));
      chk($sformatf("a_empty ch%0d", c),   W'(a_empty[c]), W'(m_ae[c]));
      chk($sformatf("a_full ch%0d", c),    W'(a_full[c]),  W'(m_af[c]));
      chk($sformatf("overflow ch%0d", c),  W'(ovf[c]),     W'(m_ovf[c]));
      chk($sformatf("underflow ch%0d", c), W'(unf[c]),     W'(m_unf[c]));
      chk($sformatf("data_cnt ch%0d", c),  W'(cnt[c*CW +: CW]), W'(mq[c].size()));
      if (hv[c]) chk($sformatf("rd_data ch%0d", c), rd_data[c*W +: W], mq[c][0]);
    end
  endtask

  // Apply current inputs for one edge, then check at the following negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    push = '0; pop = '0; clr = '0;
  endtask

  task automatic rand_phase(input int cycles, input int p_push, input int p_pop);
    for (int i = 0; i < cycles; i++) begin
      for (int c = 0; c < NCH; c++) begin
        push[c] = ($urandom_range(99) < p_push);
        pop[c]  = ($urandom_range(99) < p_pop);
        clr[c]  = ($urandom_range(15) == 0);
        wdata[c*W +: W] = $urandom;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    // ch0: ae=2 af=6; ch1: af=0 holds high; ch2: af=9 holds low; ch3: ae=7 af=8
    ae_th = {4'd7, 4'd8, 4'd0, 4'd2};
    af_th = {4'd8, 4'd9, 4'd0, 4'd6};
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    compare_all();
    for (int c = 0; c < NCH; c++) chk($sformatf("reset rd_data ch%0d", c), rd_data[c*W +: W], '0);
    step();
    step();

    // Single word into ch0: visible two edges later.
    push[0] = 1'b1; wdata[0 +: W] = 32'hA5;
    step();
    idle_inputs();
    step();
    chk("a5 head ch0", rd_data[0 +: W], 32'hA5);
    step();
    pop[0] = 1'b1;
    step();
    idle_inputs();

    // Fill ch1 with 0..7, one overflowing push, then drain.
    for (int i = 0; i < DEPTH + 1; i++) begin
      push[1] = 1'b1; wdata[1*W +: W] = W'(i);
      step();
    end
    idle_inputs();
    step();
    for (int i = 0; i < DEPTH + 1; i++) begin
      pop[1] = 1'b1;
      step();
    end
    idle_inputs();

    // Underflow on ch2, clear, then clear coincident with a new underflow.
    pop[2] = 1'b1;
    step();
    pop[2] = 1'b0; clr[2] = 1'b1;
    step();
    pop[2] = 1'b1;
    step();
    idle_inputs();
    step();

    // Streaming on ch0 through several pointer wraps, with threshold crossings.
    for (int i = 0; i < 3; i++) begin
      push[0] = 1'b1; wdata[0 +: W] = W'(32'h100 + i);
      step();
    end
    for (int i = 3; i < 3 + 3 * DEPTH; i++) begin
      push[0] = 1'b1; pop[0] = 1'b1; wdata[0 +: W] = W'(32'h100 + i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      push[0] = 1'b1; wdata[0 +: W] = W'(32'h200 + i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      pop[0] = 1'b1;
      step();
    end
    idle_inputs();

    // Randomised traffic on all channels.
    rand_phase(150, 70, 30);
    rand_phase(150, 50, 50);
    rand_phase(150, 25, 75);

    // Asynchronous reset while ch3 holds five words.
    clr = '1;
    step();
    idle_inputs();
    rand_phase(20, 0, 100);
    for (int i = 0; i < 5; i++) begin
      push[3] = 1'b1; wdata[3*W +: W] = $urandom;
      step();
    end
    idle_inputs();
    step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    for (int c = 0; c < NCH; c++) chk($sformatf("async rst rd_data ch%0d", c), rd_data[c*W +: W], '0);
    #1 rst = 1'b0;
    pop[3] = 1'b1;
    step();
    step();
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
